// File: rtl/or1200_pcu_sampler.sv
// ---------------------------------------------------------------------------
// or1200_pcu_sampler
//
// Walks the eight OR1200 performance-counter SPRs (PCU_BASE .. PCU_BASE+7)
// and stores one snapshot of them. A walk starts on trigger_i, on expiry of
// a free-running sample-period timer, or on a request that arrived while the
// previous walk was still in progress. The CPU shares the PCU SPR port and
// always has priority; the walker simply waits out any CPU access.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_spr_cs_i              CPU is accessing the PCU this cycle
//   cpu_spr_write_i/adr_i/dat_i  CPU write flag, address, write data
//   cpu_spr_dat_o             CPU read data (always pcu_spr_dat_i)
//   pcu_spr_write_o/adr_o/dat_o  muxed SPR access towards the PCU
//   pcu_spr_dat_i             PCU read data, valid one cycle after address
//   enable_i, period_i        sample timer enable and reload value
//   trigger_i                 software/debug sample request (level)
//   snap_idx_i, snap_dat_o    combinational snapshot read port
//   busy_o, done_o            walk in progress, one-cycle completion pulse
//   irq_o, irq_clr_i          sticky completion interrupt and its clear
//   overrun_o, ovr_clr_i      sticky dropped-request flag and its clear
//   snap_seq_o                count of completed walks (wraps at 256)
// ---------------------------------------------------------------------------
module or1200_pcu_sampler #(
  parameter logic [31:0] PCU_BASE = 32'h0000_3800,
  parameter int          PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_spr_cs_i,
  input  logic                cpu_spr_write_i,
  input  logic [31:0]         cpu_spr_adr_i,
  input  logic [31:0]         cpu_spr_dat_i,
  output logic [31:0]         cpu_spr_dat_o,
  output logic                pcu_spr_write_o,
  output logic [31:0]         pcu_spr_adr_o,
  output logic [31:0]         pcu_spr_dat_o,
  input  logic [31:0]         pcu_spr_dat_i,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                trigger_i,
  input  logic [2:0]          snap_idx_i,
  output logic [31:0]         snap_dat_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                irq_o,
  output logic                overrun_o,
  output logic [7:0]          snap_seq_o,
  input  logic                irq_clr_i,
  input  logic                ovr_clr_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          r_state;
  logic [2:0]          r_idx;
  logic [31:0]         r_snap [0:7];
  logic [7:0]          r_seq;
  logic                r_pending;
  logic                r_irq;
  logic                r_ovr;
  logic [PERIOD_W-1:0] r_timer;

  logic w_expire;
  logic w_req;
  logic w_busy;
  logic w_done;

  // The timer fires while it holds 1; a zero period or disabled timer never
  // fires, so a walk is only ever started by an explicit request then.
  assign w_expire = enable_i && (period_i != '0) && (r_timer == PERIOD_W'(1));
  assign w_req    = trigger_i | w_expire;
  assign w_busy   = (r_state != S_IDLE);
  assign w_done   = (r_state == S_DONE);

  assign busy_o        = w_busy;
  assign done_o        = w_done;
  assign irq_o         = r_irq;
  assign overrun_o     = r_ovr;
  assign snap_seq_o    = r_seq;
  assign snap_dat_o    = r_snap[snap_idx_i];
  assign cpu_spr_dat_o = pcu_spr_dat_i;

  // Sample-period down-counter. While disabled it tracks period_i so that
  // enabling it gives a full period before the first expiry; a zero value
  // (after reset) is reloaded before counting starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!enable_i || (period_i == '0)) begin
      r_timer <= period_i;
    end else if (w_expire || (r_timer == '0)) begin
      r_timer <= period_i;
    end else begin
      r_timer <= r_timer - PERIOD_W'(1);
    end
  end

  // Walk sequencer. ISSUE only advances when the CPU leaves the port free;
  // CAPTURE always stores because the data being returned belongs to the
  // address issued in the previous cycle, whatever the CPU does now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_seq   <= '0;
      for (int i = 0; i < 8; i++) r_snap[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req || r_pending) begin
            r_state <= S_ISSUE;
            r_idx   <= '0;
          end
        end
        S_ISSUE: begin
          if (!cpu_spr_cs_i) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_snap[r_idx] <= pcu_spr_dat_i;
          if (r_idx == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_ISSUE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_seq   <= r_seq + 8'd1;
        end
      endcase
    end
  end

  // One-deep request queue. A walk started from IDLE consumes one request;
  // if a fresh request coincides with a pending one, the fresh one stays
  // queued. While busy, the first request queues and any further request
  // is dropped and flagged as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (!w_busy) begin
      r_pending <= r_pending & w_req;
    end else if (w_req) begin
      r_pending <= 1'b1;
    end
  end

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_done)         r_irq <= 1'b1;
      else if (irq_clr_i) r_irq <= 1'b0;
      if (w_busy && w_req && r_pending) r_ovr <= 1'b1;
      else if (ovr_clr_i)               r_ovr <= 1'b0;
    end
  end

  // SPR port mux: CPU first, then the walker's read, otherwise idle zeros.
  always_comb begin
    pcu_spr_write_o = 1'b0;
    pcu_spr_adr_o   = '0;
    pcu_spr_dat_o   = '0;
    if (cpu_spr_cs_i) begin
      pcu_spr_write_o = cpu_spr_write_i;
      pcu_spr_adr_o   = cpu_spr_adr_i;
      pcu_spr_dat_o   = cpu_spr_dat_i;
    end else if (r_state == S_ISSUE) begin
      pcu_spr_adr_o   = PCU_BASE + {29'd0, r_idx};
    end
  end

endmodule

// File: doc/or1200_pcu_sampler.md
OR1200_PCU_SAMPLER -- requirements
Module: or1200_pcu_sampler

Interface
REQ-001 SHALL have parameter PCU_BASE, default 32'h0000_3800, PCU SPR base address (group 7, PCCR0 offset 0).
REQ-002 SHALL have parameter PERIOD_W, default 16, width of the sample-period timer.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port cpu_spr_cs_i, input, 1, CPU SPR access to the PCU this cycle.
REQ-006 SHALL have ports cpu_spr_write_i (1), cpu_spr_adr_i (32), cpu_spr_dat_i (32), inputs, CPU SPR write flag, address and write data.
REQ-007 SHALL have port cpu_spr_dat_o, output, 32, CPU read data, always equal to pcu_spr_dat_i.
REQ-008 SHALL have ports pcu_spr_write_o (1), pcu_spr_adr_o (32), pcu_spr_dat_o (32), outputs, muxed SPR access to the PCU.
REQ-009 SHALL have port pcu_spr_dat_i, input, 32, PCU read data, registered one cycle after the address.
REQ-010 SHALL have ports enable_i (1) and period_i (PERIOD_W), inputs, timer enable and reload value.
REQ-011 SHALL have port trigger_i, input, 1, software/debug sample request (level sampled each cycle).
REQ-012 SHALL have ports snap_idx_i (3) input and snap_dat_o (32) output, combinational read of snapshot entry.
REQ-013 SHALL have outputs busy_o (1), done_o (1 pulse), irq_o (1), overrun_o (1), snap_seq_o (8); irq_clr_i (1) and ovr_clr_i (1) inputs.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> (ISSUE for next index | DONE) -> IDLE, with a 3-bit walk index idx.
REQ-015 SHALL enter ISSUE with idx=0 from IDLE when a request (trigger_i, timer expiry, or pending flag) is present.
REQ-016 In ISSUE with cpu_spr_cs_i=0, SHALL drive pcu_spr_adr_o=PCU_BASE+idx, pcu_spr_write_o=0, pcu_spr_dat_o=0, and advance to CAPTURE.
REQ-017 Whenever cpu_spr_cs_i=1, SHALL pass CPU write/address/data straight to the PCU ports (CPU has absolute priority); in ISSUE the FSM SHALL hold and reissue the same idx.
REQ-018 In CAPTURE SHALL store pcu_spr_dat_i into snap[idx] regardless of cpu_spr_cs_i; idx=7 goes to DONE, else idx+1 and ISSUE.
REQ-019 When no CPU access and FSM not in ISSUE, PCU ports SHALL be driven to zero (read of address 0 disabled: pcu_spr_adr_o=0).
REQ-020 DONE SHALL last one cycle: done_o=1, snap_seq_o increments (mod 256 wrap), irq_o set.
REQ-021 busy_o SHALL be 1 in ISSUE, CAPTURE, DONE; uncontended walk is 17 cycles from request to done_o.
REQ-022 Timer: when enable_i=1 and period_i!=0, down-counter loads period_i, decrements each cycle, and on value 1 issues an expiry and reloads; period_i=0 or enable_i=0 holds counter at period_i (no expiry).
REQ-023 Request while busy SHALL set the one-deep pending flag; request while pending already set SHALL set sticky overrun_o and be dropped.
REQ-024 Pending request SHALL start a new walk the cycle after DONE; pending clears on that start.
REQ-025 irq_o sticky until irq_clr_i; simultaneous set and clear SHALL leave irq_o=1. ovr_clr_i clears overrun_o, same set-wins rule.
REQ-026 enable_i deassert mid-walk SHALL not abort the walk.

Reset
REQ-027 On rst: FSM IDLE, idx=0, snap[0..7]=0, snap_seq_o=0, pending=0, timer=0, busy_o=done_o=irq_o=overrun_o=0, pcu ports 0; asynchronous, including mid-walk.

Verification
REQ-028 trigger_i 1 cycle, PCU model returning 32'h100+idx -> adr sequence 0x3800..0x3807, snap[i]=0x100+i, done_o at cycle 17, snap_seq_o=1, irq_o=1.
REQ-029 cpu_spr_cs_i high 3 cycles during ISSUE idx=2 -> CPU address/data on PCU ports, walk resumes at 0x3802, done_o delayed by 3 cycles, snap values correct.
REQ-030 enable_i=1, period_i=20 -> done_o every 20 cycles, snap_seq_o 1,2,3; period_i=0 -> no further walks.
REQ-031 Two trigger_i pulses during one walk -> one extra walk back-to-back after DONE, overrun_o=1 after second; ovr_clr_i clears it.
REQ-032 rst asserted at idx=4 -> all outputs 0 immediately, snap entries 0, next trigger_i restarts at 0x3800.
REQ-033 irq_clr_i coincident with done_o -> irq_o stays 1; irq_clr_i alone next cycle -> irq_o=0.
